axi_w_fifo_drain: RTL and testbench
===================================

Name: axi_w_fifo_drain

Overview:
- Read-side consumer of the AXI write-data clock-crossing FIFO.
- Accepts a burst length from the AW path, then pops that many {last, strb, data} entries from the FIFO's first-word-fall-through read port.
- Presents the beats on a registered AXI W master interface toward the slave and generates WLAST from its own beat count.
- Sits in the slave clock domain, directly downstream of the FIFO read port.

Parameters:
- DATA_W, 32, WDATA width.
- STRB_W, 4, WSTRB width (DATA_W/8).
- LEN_W, 8, AXI burst length width (beats = len+1).

Ports:
- clk  in  1  slave-domain clock.
- rst_n  in  1  synchronous active-low reset.
- len_valid  in  1  burst length available.
- len  in  LEN_W  AXI AWLEN (beats-1).
- len_ready  out  1  length accepted this cycle when len_valid&&len_ready.
- fifo_empty  in  1  FIFO read port empty.
- fifo_data  in  DATA_W+STRB_W+1  head entry: [top]=last, next STRB_W bits=strb, low DATA_W bits=data; combinationally valid when !fifo_empty.
- fifo_pop  out  1  consume head entry this cycle.
- WDATA  out  DATA_W  write data.
- WSTRB  out  STRB_W  byte strobes.
- WLAST  out  1  final beat of burst.
- WVALID  out  1  beat valid.
- WREADY  in  1  slave accepts beat.
- busy  out  1  state != IDLE.
- last_err  out  1  sticky last-bit mismatch flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous, active-low, and sampled on posedge clk.
- Reset values: state=IDLE, WVALID=0, WDATA=0, WSTRB=0, WLAST=0, beat_cnt=0, len_q=0, last_err=0. fifo_pop=0 while rst_n=0.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - len_ready=1 (combinational from state); len_ready=0 in all other states.
  - On len_valid: len_q<=len, beat_cnt<=0, go to BURST.
- Output register load condition: load = (state==BURST) && !fifo_empty && (!WVALID || WREADY).
- On load:
  - fifo_pop=1 in the same cycle (fifo_pop is combinational and equal to load).
  - WDATA/WSTRB <= fifo_data fields; WVALID<=1.
  - WLAST <= (beat_cnt==len_q); beat_cnt<=beat_cnt+1.
  - If beat_cnt==len_q, go to DRAIN.
- No-load cycle: WVALID&&WREADY clears WVALID. Otherwise WVALID and the payload hold stable while WVALID=1 && WREADY=0 (AXI rule). Never pop while stalled.
- DRAIN: when WVALID&&WREADY, WVALID<=0 and go to IDLE.
- Latency:
  - len accepted at edge N, first WVALID high after edge N+1 if the FIFO is non-empty.
  - Back-to-back beats at 1 per cycle while WREADY=1 and the FIFO is non-empty.
  - One idle cycle between bursts: DRAIN to IDLE, then IDLE accepting len.
- Boundaries:
  - FIFO empty mid-burst: WVALID drops after the current beat is accepted, beat_cnt holds, and the burst resumes when data arrives.
  - len=0: single beat, WLAST=1.
  - len=255: 256 beats. beat_cnt is LEN_W+1 bits wide so it cannot wrap before the compare.
  - len_valid outside IDLE is ignored.
  - Reset mid-burst: immediate return to reset values. Beats already popped are lost; the FIFO side is reset by its own reset.
- busy=1 in BURST and DRAIN.

Optional Feature:
- Macro: W_LAST_CHECK_EN.
- Defined: on each load, compare fifo_data last bit with (beat_cnt==len_q). On mismatch, last_err<=1; it stays set until reset. WLAST is always driven from the counter, never from the FIFO bit.
- Undefined: no comparison logic; last_err tied to 0.

Test Plan:
- Reset → all outputs 0, len_ready=1, fifo_pop=0.
- len=3, FIFO preloaded with 4 entries, WREADY=1 → 4 consecutive beats, WLAST only on 4th, 4 pops, busy drops after DRAIN, len_ready=1 again.
- len=0, one entry, WREADY held 0 for 5 cycles then 1 → WVALID/WDATA/WLAST=1 stable all 5 cycles, single pop, return to IDLE.
- len=7, FIFO supplies entries with a gap (empty 3 cycles after beat 2) → WVALID low during gap, 8 beats total in order, WLAST on 8th.
- len=255 with random WREADY → exactly 256 accepted beats, data order preserved, WLAST on the last only.
- With W_LAST_CHECK_EN, len=1 with FIFO last bit set on beat 0 → last_err=1 after that load and stays 1; without the macro, last_err=0.

Source files
------------

// File: rtl/axi_w_fifo_drain_if.sv
// AXI write-data (W) channel bundle between the FIFO drain and the downstream slave.
interface axi_w_fifo_drain_if #(
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
) ();
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;

    modport master (output WDATA, output WSTRB, output WLAST, output WVALID, input WREADY);
    modport slave  (input WDATA, input WSTRB, input WLAST, input WVALID, output WREADY);
endinterface

// File: rtl/axi_w_fifo_drain.sv
// Drains one AW-sized burst from a FWFT write-data FIFO onto a registered AXI W master port.
// Optional W_LAST_CHECK_EN: flags a sticky error when the FIFO last bit disagrees with the beat count.
module axi_w_fifo_drain #(
    parameter int DATA_W = 32,
    parameter int STRB_W = 4,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     len_valid,
    input  logic [LEN_W-1:0]         len,
    output logic                     len_ready,
    input  logic                     fifo_empty,
    input  logic [DATA_W+STRB_W:0]   fifo_data,
    output logic                     fifo_pop,
    axi_w_fifo_drain_if.master       w,
    output logic                     busy,
    output logic                     last_err
);
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [LEN_W:0]   beat_cnt;
    logic [LEN_W-1:0] len_q;
    logic             load;
    logic             last_beat;

    // One extra counter bit so len=255 reaches the compare without wrapping.
    assign last_beat = (beat_cnt == {1'b0, len_q});
    assign busy      = (state != IDLE);
    // Gated so nothing is consumed while reset is held, whatever state is pending.
    assign fifo_pop  = load & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        len_ready = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                len_ready = 1'b1;
                if (len_valid) state_nxt = BURST;
            end
            BURST: begin
                load = !fifo_empty && (!w.WVALID || w.WREADY);
                if (load && last_beat) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w.WVALID && w.WREADY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w.WVALID <= 1'b0;
            w.WDATA  <= '0;
            w.WSTRB  <= '0;
            w.WLAST  <= 1'b0;
            beat_cnt <= '0;
            len_q    <= '0;
        end else begin
            if (state == IDLE && len_valid) begin
                len_q    <= len;
                beat_cnt <= '0;
            end
            if (load) begin
                w.WDATA  <= fifo_data[DATA_W-1:0];
                w.WSTRB  <= fifo_data[DATA_W +: STRB_W];
                w.WLAST  <= last_beat;
                w.WVALID <= 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end else if (w.WVALID && w.WREADY) begin
                w.WVALID <= 1'b0;
            end
        end
    end

`ifdef W_LAST_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_err <= 1'b0;
        else if (load && (fifo_data[DATA_W+STRB_W] != last_beat))
            last_err <= 1'b1;
    end
`else
    logic unused_fifo_last;
    assign unused_fifo_last = fifo_data[DATA_W+STRB_W];
    assign last_err         = 1'b0;
`endif
endmodule

// File: tb/tb_axi_w_fifo_drain.sv
// Directed bench for axi_w_fifo_drain: FWFT FIFO model, W-channel beat monitor, assertion checks.
module tb_axi_w_fifo_drain;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int LEN_W  = 8;
`ifdef W_LAST_CHECK_EN
    localparam logic EXP_LERR = 1'b1;
`else
    localparam logic EXP_LERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic len_valid;
    logic [LEN_W-1:0] len;
    logic len_ready;
    logic fifo_empty;
    logic [DATA_W+STRB_W:0] fifo_data;
    logic fifo_pop;
    logic busy;
    logic last_err;

    axi_w_fifo_drain_if #(.DATA_W(DATA_W), .STRB_W(STRB_W)) w ();

    axi_w_fifo_drain #(.DATA_W(DATA_W), .STRB_W(STRB_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .len_valid(len_valid), .len(len), .len_ready(len_ready),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .w(w.master), .busy(busy), .last_err(last_err)
    );

    always #5 clk = ~clk;

    // FIFO model: entries written by the stimulus, head consumed on fifo_pop.
    logic [DATA_W+STRB_W:0] mem [0:511];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    logic hold = 1'b0;
    assign fifo_empty = (rd_ptr == wr_ptr) || hold;
    assign fifo_data  = mem[rd_ptr[8:0]];
    always @(posedge clk) if (fifo_pop) rd_ptr <= rd_ptr + 1;

    // Beat monitor
    logic [DATA_W-1:0] cap_data [0:511];
    logic              cap_last [0:511];
    int cap_n = 0;
    always @(posedge clk)
        if (rst_n && w.WVALID && w.WREADY) begin
            cap_data[cap_n[8:0]] <= w.WDATA;
            cap_last[cap_n[8:0]] <= w.WLAST;
            cap_n <= cap_n + 1;
        end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic last, input logic [STRB_W-1:0] strb, input logic [DATA_W-1:0] data);
        mem[wr_ptr[8:0]] = {last, strb, data};
        wr_ptr++;
    endtask

    initial begin
        int base, mism, nlast, rd0;
        rst_n = 1'b0; len_valid = 1'b0; len = '0; w.WREADY = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_wvalid", w.WVALID, 0);
        chk("rst_wdata", w.WDATA, 0);
        chk("rst_wstrb", w.WSTRB, 0);
        chk("rst_wlast", w.WLAST, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_ready", len_ready, 1);
        chk("rst_fifo_pop", fifo_pop, 0);
        chk("rst_last_err", last_err, 0);

        // len=3, 4 preloaded entries, WREADY=1
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(i == 3, 4'hF, 32'hA000_0000 + i);
        base = cap_n;
        w.WREADY = 1'b1; len_valid = 1'b1; len = 8'd3;
        step();
        len_valid = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_len_ready", len_ready, 0);
        chk("t1_first_pop", fifo_pop, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_wvalid", w.WVALID, 1);
            chk("t1_wdata", w.WDATA, 32'hA000_0000 + k);
            chk("t1_wlast", w.WLAST, (k == 3) ? 1 : 0);
        end
        chk("t1_drain_pop", fifo_pop, 0);
        step();
        chk("t1_end_wvalid", w.WVALID, 0);
        chk("t1_end_busy", busy, 0);
        chk("t1_end_len_ready", len_ready, 1);
        chk("t1_pops", rd_ptr, 4);
        chk("t1_beats", cap_n - base, 4);

        // len=0 single beat with WREADY stalled 5 cycles
        push(1'b1, 4'h3, 32'h5555_AAAA);
        w.WREADY = 1'b0; len_valid = 1'b1; len = 8'd0;
        step();
        len_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_wvalid", w.WVALID, 1);
            chk("t2_wdata", w.WDATA, 32'h5555_AAAA);
            chk("t2_wstrb", w.WSTRB, 4'h3);
            chk("t2_wlast", w.WLAST, 1);
            chk("t2_no_pop", fifo_pop, 0);
            if (i < 4) step();
        end
        w.WREADY = 1'b1;
        step();
        chk("t2_end_wvalid", w.WVALID, 0);
        chk("t2_end_busy", busy, 0);
        chk("t2_pops", rd_ptr, 5);

        // len=7 with a 3-cycle FIFO gap after beat 2; stray len_valid ignored mid-burst
        for (int i = 0; i < 8; i++) push(i == 7, 4'h5, 32'hB000_0000 + i);
        base = cap_n;
        len_valid = 1'b1; len = 8'd7;
        step();
        len_valid = 1'b0;
        repeat (3) step();
        chk("t3_beat2", w.WDATA, 32'hB000_0002);
        hold = 1'b1;
        step();
        chk("t3_gap_wvalid0", w.WVALID, 0);
        len_valid = 1'b1; len = 8'd0;
        chk("t3_len_ready_busy", len_ready, 0);
        step();
        len_valid = 1'b0;
        chk("t3_gap_wvalid1", w.WVALID, 0);
        step();
        chk("t3_gap_wvalid2", w.WVALID, 0);
        hold = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (!busy) break;
        end
        chk("t3_done", busy, 0);
        chk("t3_beats", cap_n - base, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t3_order", cap_data[base + i], 32'hB000_0000 + i);
            chk("t3_last", cap_last[base + i], (i == 7) ? 1 : 0);
        end

        // len=255 with random WREADY
        for (int i = 0; i < 256; i++) push(i == 255, 4'hF, 32'hC000_0000 + i);
        base = cap_n; rd0 = rd_ptr;
        len_valid = 1'b1; len = 8'd255;
        step();
        len_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            w.WREADY = 1'($urandom_range(0, 1));
            step();
            if (!busy) break;
        end
        w.WREADY = 1'b1;
        chk("t4_done", busy, 0);
        chk("t4_beats", cap_n - base, 256);
        chk("t4_pops", rd_ptr - rd0, 256);
        mism = 0; nlast = 0;
        for (int i = 0; i < 256; i++) begin
            if (cap_data[base + i] !== 32'hC000_0000 + i) mism++;
            if (cap_last[base + i] === 1'b1) nlast++;
        end
        chk("t4_order_mism", mism, 0);
        chk("t4_last_count", nlast, 1);
        chk("t4_last_pos", cap_last[base + 255], 1);

        // last-bit check: beat 0 carries last=1 although len=1
        push(1'b1, 4'hF, 32'hD000_0000);
        push(1'b1, 4'hF, 32'hD000_0001);
        len_valid = 1'b1; len = 8'd1;
        step();
        len_valid = 1'b0;
        step();
        chk("t5_wlast_counter", w.WLAST, 0);
        chk("t5_last_err", last_err, EXP_LERR);
        repeat (2) step();
        chk("t5_busy", busy, 0);
        chk("t5_last_err_sticky", last_err, EXP_LERR);

        // reset mid-burst
        push(1'b0, 4'hF, 32'hE000_0000);
        push(1'b0, 4'hF, 32'hE000_0001);
        w.WREADY = 1'b0;
        len_valid = 1'b1; len = 8'd3;
        step();
        len_valid = 1'b0;
        step();
        chk("t6_wvalid_pre", w.WVALID, 1);
        w.WREADY = 1'b1;
        rst_n = 1'b0;
        chk("t6_pop_in_rst", fifo_pop, 0);
        step();
        chk("t6_wvalid", w.WVALID, 0);
        chk("t6_wdata", w.WDATA, 0);
        chk("t6_busy", busy, 0);
        chk("t6_len_ready", len_ready, 1);
        chk("t6_last_err", last_err, 0);
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
